// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolution: in-order FIFO of fetch-time predictions, compared at EX to raise BTB
// update strobes, a fetch redirect and a timed flush. Optional perf counters under BRU_PERF_CNT_EN.
module branch_resolve_unit #(
    parameter int DEPTH        = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_valid,
    output logic        fetch_ready,
    input  logic [31:0] fetch_pc,
    input  logic [31:0] fetch_pred_pc,
    input  logic        fetch_btb_hit,
    input  logic [1:0]  fetch_btb_idx,
    input  logic        ex_valid,
    input  logic        ex_is_branch,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    output logic        alu_recover1,
    output logic        alu_recover2,
    output logic        pcplus4_recover,
    output logic [31:0] pc_branch,
    output logic [31:0] target_address,
    output logic [1:0]  BTB_kill_idx,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
`ifdef BRU_PERF_CNT_EN
    output logic [31:0] perf_branches,
    output logic [31:0] perf_mispredicts,
`endif
    output logic        flush
);

    localparam int AW  = $clog2(DEPTH);
    localparam int CTW = AW + 1;
    localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    typedef enum logic {S_RUN = 1'b0, S_FLUSH = 1'b1} state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [FCW-1:0]   r_flush_cnt;

    logic [31:0]      r_pc_mem   [DEPTH];
    logic [31:0]      r_pred_mem [DEPTH];
    logic             r_hit_mem  [DEPTH];
    logic [1:0]       r_idx_mem  [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CTW-1:0]   r_count;

    logic             w_full, w_empty, w_push, w_pop, w_taken, w_mis, w_enter_flush;
    logic [31:0]      w_head_pc, w_head_pred, w_actual;
    logic             w_head_hit;
    logic [1:0]       w_head_idx;

    logic             r_rec1, r_rec2, r_rec_p4, r_redirect_valid;
    logic [31:0]      r_pc_branch, r_target_address, r_redirect_pc;
    logic [1:0]       r_kill_idx;

    assign w_full      = (r_count == CTW'(DEPTH));
    assign w_empty     = (r_count == '0);
    assign w_push      = fetch_valid && fetch_ready;
    assign w_pop       = ex_valid && (r_state == S_RUN) && !w_empty;
    assign w_head_pc   = r_pc_mem[r_rd_ptr];
    assign w_head_pred = r_pred_mem[r_rd_ptr];
    assign w_head_hit  = r_hit_mem[r_rd_ptr];
    assign w_head_idx  = r_idx_mem[r_rd_ptr];
    assign w_taken     = ex_is_branch && ex_taken;
    assign w_actual    = w_taken ? ex_target : (w_head_pc + 32'd4);
    assign w_mis       = (w_actual != w_head_pred);
    assign w_enter_flush = (r_state == S_RUN) && (w_state_next == S_FLUSH);

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_RUN;
            r_flush_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_enter_flush)
                r_flush_cnt <= FCW'(FLUSH_CYCLES - 1);
            else if (r_state == S_FLUSH && r_flush_cnt != '0)
                r_flush_cnt <= r_flush_cnt - FCW'(1);
        end
    end

    // FSM: next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_RUN:   if (w_pop && w_mis) w_state_next = S_FLUSH;
            S_FLUSH: if (r_flush_cnt == '0) w_state_next = S_RUN;
            default: w_state_next = S_RUN;
        endcase
    end

    // FSM: outputs
    always_comb begin
        flush       = (r_state == S_FLUSH);
        fetch_ready = (r_state == S_RUN) && !w_full;
    end

    // Entry storage carries no reset; only slots behind valid pointers are ever read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc_mem[r_wr_ptr]   <= fetch_pc;
            r_pred_mem[r_wr_ptr] <= fetch_pred_pc;
            r_hit_mem[r_wr_ptr]  <= fetch_btb_hit;
            r_idx_mem[r_wr_ptr]  <= fetch_btb_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || w_enter_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CTW'(1);
                2'b01:   r_count <= r_count - CTW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rec1           <= 1'b0;
            r_rec2           <= 1'b0;
            r_rec_p4         <= 1'b0;
            r_redirect_valid <= 1'b0;
            r_pc_branch      <= '0;
            r_target_address <= '0;
            r_kill_idx       <= '0;
            r_redirect_pc    <= '0;
        end else begin
            r_rec1           <= w_pop && w_taken && !w_head_hit;
            r_rec2           <= w_pop && w_taken && w_head_hit && w_mis;
            r_rec_p4         <= w_pop && !w_taken && w_head_hit && w_mis;
            r_redirect_valid <= w_pop && w_mis;
            if (w_pop) begin
                r_pc_branch      <= w_head_pc;
                r_target_address <= ex_target;
                r_kill_idx       <= w_head_idx;
            end
            if (w_pop && w_mis)
                r_redirect_pc <= w_actual;
        end
    end

    assign alu_recover1    = r_rec1;
    assign alu_recover2    = r_rec2;
    assign pcplus4_recover = r_rec_p4;
    assign redirect_valid  = r_redirect_valid;
    assign redirect_pc     = r_redirect_pc;
    assign pc_branch       = r_pc_branch;
    assign target_address  = r_target_address;
    assign BTB_kill_idx    = r_kill_idx;

`ifdef BRU_PERF_CNT_EN
    logic [31:0] r_perf_br, r_perf_mis;

    // Saturating counters; mispredicts include non-branch fall-through mispredictions.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_br  <= '0;
            r_perf_mis <= '0;
        end else begin
            if (w_pop && ex_is_branch && r_perf_br != 32'hFFFF_FFFF)
                r_perf_br <= r_perf_br + 32'd1;
            if (w_pop && w_mis && r_perf_mis != 32'hFFFF_FFFF)
                r_perf_mis <= r_perf_mis + 32'd1;
        end
    end

    assign perf_branches    = r_perf_br;
    assign perf_mispredicts = r_perf_mis;
`endif

endmodule
